ntable_attr_writer: RTL and testbench

NTABLE_ATTR_WRITER -- requirements
Module: ntable_attr_writer

---
 rtl/ntable_attr_writer_pkg.sv | 30 +++
 rtl/attr_line_buf.sv | 34 +++
 rtl/ntable_attr_writer.sv | 142 ++++++++++++++
 tb/tb_ntable_attr_writer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntable_attr_writer_pkg.sv
// Shared constants, FSM state encoding and address helper for the
// nametable attribute writer.
package ntable_attr_writer_pkg;

    // Frame geometry in 16x16 metatiles
    localparam int unsigned METATILE_COLS = 16;
    localparam int unsigned METATILE_ROWS = 15;

    // Attribute table geometry: one byte covers a 2x2 block of metatiles
    localparam int unsigned ATTR_COLS  = 8;
    localparam int unsigned ATTR_BYTES = 64;

    localparam int unsigned FRAME_XFERS = METATILE_COLS * METATILE_ROWS;

    // Line buffer index width
    localparam int unsigned LB_IDX_W = $clog2(ATTR_COLS);

    // FSM state type, kept as plain encoded constants
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Byte address of the attribute byte holding metatile (row, col)
    function automatic logic [5:0] attr_addr(input logic [3:0] row, input logic [3:0] col);
        return {row[3:1], col[3:1]};
    endfunction

endpackage

// File: rtl/attr_line_buf.sv
// 8-entry x 4-bit line buffer holding the top-half quadrants of each
// attribute byte while the odd (bottom) metatile row streams in.
module attr_line_buf
    import ntable_attr_writer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [LB_IDX_W-1:0] wr_idx,
    input  logic                wr_hi,
    input  logic [1:0]          wr_val,
    input  logic [LB_IDX_W-1:0] rd_idx,
    output logic [3:0]          rd_val
);

    logic [3:0] mem_q [ATTR_COLS];

    // Entry storage: wr_hi selects top-right [3:2], otherwise top-left [1:0]
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            mem_q <= '{default: 4'h0};
        end else if (wr_en) begin
            if (wr_hi) begin
                mem_q[wr_idx][3:2] <= wr_val;
            end else begin
                mem_q[wr_idx][1:0] <= wr_val;
            end
        end
    end

    assign rd_val = mem_q[rd_idx];

endmodule

// File: rtl/ntable_attr_writer.sv
// Packs a raster-order stream of metatile palette indices into the
// 64-byte attribute table, issuing one registered write per 2x2 block.
module ntable_attr_writer
    import ntable_attr_writer_pkg::*;
#(
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [1:0]        in_pal,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [3:0]        col_q, col_d;
    logic [3:0]        row_q, row_d;
    logic [1:0]        hold_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;

    logic              xfer;
    logic              arm;
    logic              last_col;
    logic              last_row;
    logic              wr_fire;
    logic [7:0]        byte_d;
    logic [ADDR_W-1:0] addr_d;
    logic [3:0]        lb_rd;

    assign xfer     = in_valid && (state_q == ST_RUN);
    assign arm      = start && (state_q == ST_IDLE);
    assign last_col = (col_q == 4'(METATILE_COLS - 1));
    assign last_row = (row_q == 4'(METATILE_ROWS - 1));

    // A byte completes on the bottom-right metatile, or on the top-right one
    // for the final (unpaired) row.
    assign wr_fire = xfer && col_q[0] && (row_q[0] || last_row);
    assign addr_d  = ADDR_W'(attr_addr(row_q, col_q));

    // Assemble the outgoing byte from the line buffer, hold register and input
    always_comb begin
        byte_d = 8'h00;
        if (row_q[0]) begin
            byte_d = {in_pal, hold_q, lb_rd};
        end else begin
            byte_d = {4'h0, in_pal, lb_rd[1:0]};
        end
    end

    // Next-state logic for the frame FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (xfer && last_col && last_row) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Column/row counters: cleared on arm, advanced only on a transfer
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (arm) begin
            col_d = 4'd0;
            row_d = 4'd0;
        end else if (xfer) begin
            if (last_col) begin
                col_d = 4'd0;
                row_d = row_q + 4'd1;
            end else begin
                col_d = col_q + 4'd1;
            end
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= 4'd0;
            row_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Bottom-left quadrant held until its right-hand neighbour arrives
    always_ff @(posedge clk) begin
        if (rst || arm) begin
            hold_q <= 2'b00;
        end else if (xfer && row_q[0] && !col_q[0]) begin
            hold_q <= in_pal;
        end
    end

    // Registered write port; address/data only move when a write issues
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
        end else begin
            wr_en_q <= wr_fire;
            if (wr_fire) begin
                wr_addr_q <= addr_d;
                wr_data_q <= byte_d;
            end
        end
    end

    attr_line_buf u_line_buf (
        .clk    (clk),
        .rst    (rst),
        .clr    (arm),
        .wr_en  (xfer && !row_q[0]),
        .wr_idx (col_q[3:1]),
        .wr_hi  (col_q[0]),
        .wr_val (in_pal),
        .rd_idx (col_q[3:1]),
        .rd_val (lb_rd)
    );

    assign in_ready = (state_q == ST_RUN);
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_ntable_attr_writer.sv
// Directed bench for ntable_attr_writer: full frames with several palette
// patterns, input gaps, mid-frame reset, ignored start/in_valid, and
// back-to-back frames.
module tb_ntable_attr_writer;

    localparam int ADDR_W = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [1:0]        in_pal;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned q_addr[$];
    int unsigned q_data[$];
    int          done_cnt;
    int          done_with_last;

    ntable_attr_writer #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_pal   (in_pal),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Palette index of metatile (r, c) for each stimulus pattern
    function automatic int pal_of(input int pat, input int r, input int c);
        case (pat)
            0:       return 3;
            1:       return (c % 2) + 2 * (r % 2);
            default: return (r * 3 + c * 5 + 1) % 4;
        endcase
    endfunction

    // Expected attribute byte at address a
    function automatic int exp_byte(input int pat, input int a);
        int rr = (a / 8) * 2;
        int cc = (a % 8) * 2;
        int b;
        b = pal_of(pat, rr, cc) | (pal_of(pat, rr, cc + 1) << 2);
        if (rr + 1 < 15) begin
            b = b | (pal_of(pat, rr + 1, cc) << 4) | (pal_of(pat, rr + 1, cc + 1) << 6);
        end
        return b;
    endfunction

    // Write/done monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            q_addr.push_back(int'(wr_addr));
            q_data.push_back(int'(wr_data));
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (wr_en === 1'b1 && wr_addr == 7'd63) done_with_last++;
        end
    end

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        done_cnt       = 0;
        done_with_last = 0;
    endtask

    task automatic check_writes(input int pat, input int n);
        check_eq("wr_count", q_addr.size(), n);
        for (int i = 0; i < n && i < q_addr.size(); i++) begin
            check_eq($sformatf("wr_addr[%0d]", i), q_addr[i], i);
            check_eq($sformatf("wr_data[%0d]", i), q_data[i], exp_byte(pat, i));
        end
    endtask

    task automatic check_frame(input int pat);
        check_writes(pat, 64);
        check_eq("done_cnt", done_cnt, 1);
        check_eq("done_at_63", done_with_last, 1);
    endtask

    // Arm a frame and push n transfers; for a full frame, run through DONE
    // and return in the IDLE cycle right after it.
    task automatic do_frame(input int pat, input int gap, input bit noise, input int n);
        int idx = 0;
        int cyc = 0;
        bit v;
        bit rdy;
        clear_log();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (idx < n && cyc < 4000) begin
            @(negedge clk);
            v        = (gap == 0) || ($urandom_range(99) >= gap);
            in_valid = v;
            in_pal   = 2'(pal_of(pat, idx / 16, idx % 16));
            start    = noise && (cyc % 17 == 5);
            rdy      = in_ready;
            @(posedge clk);
            #1;
            if (v && rdy) idx++;
            cyc++;
        end
        start = 1'b0;
        check_eq("xfers", idx, n);
        if (n == 240) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (noise) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (noise) begin
                @(negedge clk);
                check_eq("busy_after_done_start", busy, 0);
                check_eq("rdy_after_done_start", in_ready, 0);
            end
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"}, in_ready, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_wr_en"}, wr_en, 0);
        check_eq({tag, "_wr_addr"}, wr_addr, 0);
        check_eq({tag, "_wr_data"}, wr_data, 0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_pal   = 2'd0;
        clear_log();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;

        // in_valid while IDLE must not be accepted
        clear_log();
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_pal   = 2'd3;
            check_eq("rdy_idle", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("idle_writes", q_addr.size(), 0);

        // Three back-to-back frames: all-3, quadrant pattern, quadrant with gaps
        do_frame(0, 0, 1'b0, 240);
        check_frame(0);
        do_frame(1, 0, 1'b0, 240);
        check_frame(1);
        do_frame(1, 50, 1'b0, 240);
        check_frame(1);

        // Abort after 100 transfers
        do_frame(2, 0, 1'b0, 100);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_writes(2, 24);
        check_eq("abort_done_cnt", done_cnt, 0);

        // Full frame after abort with start pulses during RUN and DONE
        do_frame(2, 0, 1'b1, 240);
        check_frame(2);

        // Another frame afterwards must restart cleanly at address 0
        do_frame(1, 0, 1'b0, 240);
        check_frame(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
